// File: rtl/t_pio_pkg.sv
// Shared definitions for the pulse generator: register map, CTRL/STATUS
// bit positions and FSM state encoding.
package t_pio_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_HIGH   = 3'd2;
    localparam logic [2:0] ADDR_LOW    = 3'd3;
    localparam logic [2:0] ADDR_NUM    = 3'd4;
    localparam logic [2:0] ADDR_MASK   = 3'd5;
    localparam logic [2:0] ADDR_DONE   = 3'd6;
    localparam logic [2:0] ADDR_REMAIN = 3'd7;

    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_POL   = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_OUT  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/t_phase_cnt.sv
// Phase-length down counter: loads a length, counts down to 1 and holds there.
// The terminal flag marks the last cycle of the current phase.
module t_phase_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_term
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority; decrement saturates at 1 so the counter never wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt > CNT_W'(1))) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_term = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/t_pulse_gen.sv
// Avalon-MM programmable pulse-train generator. Produces HIGH_CNT cycles of
// ~POL followed by LOW_CNT cycles of POL, repeated PULSE_NUM times (0 means
// run until STOP), and flags completion in DONE_CAP / irq.
module t_pulse_gen
    import t_pio_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        out_port
);

    // Phase length of zero is treated as one cycle.
    function automatic logic [CNT_W-1:0] f_at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    state_t           r_state;
    logic             r_out;
    logic             r_pol;
    logic [CNT_W-1:0] r_high_cnt;
    logic [CNT_W-1:0] r_low_cnt;
    logic [CNT_W-1:0] r_pulse_num;
    logic [CNT_W-1:0] r_remain;
    logic             r_cont;
    logic             r_irq_mask;
    logic             r_done;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic             w_ctrl_wr;
    logic             w_start;
    logic             w_stop;
    logic             w_pol_nxt;
    logic             w_busy;
    logic             w_last;
    logic             w_done_set;
    logic             w_done_clr;
    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_cnt_dec;
    logic             w_cnt_term;
    logic             w_unused_wdata;

    assign w_wr       = chipselect & ~write_n;
    assign w_ctrl_wr  = w_wr && (address == ADDR_CTRL);
    assign w_start    = w_ctrl_wr && writedata[CTRL_START];
    assign w_stop     = w_ctrl_wr && writedata[CTRL_STOP];
    // A CTRL write updates POL in the same cycle, so a START+POL write uses the new level.
    assign w_pol_nxt  = w_ctrl_wr ? writedata[CTRL_POL] : r_pol;
    assign w_busy     = (r_state != ST_IDLE);
    // Last LOW phase of a finite train: REMAIN is about to reach zero.
    assign w_last     = ~r_cont && (r_remain == CNT_W'(1));
    assign w_done_set = ~w_stop && (r_state == ST_LOW) && w_cnt_term && w_last;
    assign w_done_clr = w_wr && (address == ADDR_DONE);
    assign w_unused_wdata = ^writedata;

    // Phase counter control: load on each phase entry, otherwise count down.
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = f_at_least_one(r_high_cnt);
        w_cnt_dec  = 1'b0;
        if (!w_stop) begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_load = w_start;
                end
                ST_HIGH: begin
                    if (w_cnt_term) begin
                        w_cnt_load = 1'b1;
                        w_cnt_val  = f_at_least_one(r_low_cnt);
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (w_cnt_term) begin
                        w_cnt_load = ~w_last;
                    end else begin
                        w_cnt_dec = 1'b1;
                    end
                end
                default: begin
                    w_cnt_load = 1'b0;
                end
            endcase
        end
    end

    t_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_term     (w_cnt_term)
    );

    // Writable configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pol       <= 1'b0;
            r_high_cnt  <= '0;
            r_low_cnt   <= '0;
            r_pulse_num <= '0;
            r_irq_mask  <= 1'b0;
        end else begin
            r_pol <= w_pol_nxt;
            if (w_wr) begin
                case (address)
                    ADDR_HIGH: r_high_cnt  <= writedata[CNT_W-1:0];
                    ADDR_LOW:  r_low_cnt   <= writedata[CNT_W-1:0];
                    ADDR_NUM:  r_pulse_num <= writedata[CNT_W-1:0];
                    ADDR_MASK: r_irq_mask  <= writedata[0];
                    default:   ;
                endcase
            end
        end
    end

    // Pulse FSM with registered output level, pulse bookkeeping and done capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_out    <= 1'b0;
            r_remain <= '0;
            r_cont   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_done_clr) begin
                r_done <= 1'b0;
            end else if (w_done_set) begin
                r_done <= 1'b1;
            end

            if (w_stop) begin
                r_state <= ST_IDLE;
                r_out   <= w_pol_nxt;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_state  <= ST_HIGH;
                            r_out    <= ~w_pol_nxt;
                            r_remain <= r_pulse_num;
                            r_cont   <= (r_pulse_num == '0);
                        end else begin
                            r_out <= w_pol_nxt;
                        end
                    end
                    ST_HIGH: begin
                        if (w_cnt_term) begin
                            r_state <= ST_LOW;
                            r_out   <= w_pol_nxt;
                        end
                    end
                    ST_LOW: begin
                        if (w_cnt_term) begin
                            if (!r_cont) begin
                                r_remain <= r_remain - CNT_W'(1);
                            end
                            if (w_last) begin
                                r_state <= ST_IDLE;
                                r_out   <= w_pol_nxt;
                            end else begin
                                r_state <= ST_HIGH;
                                r_out   <= ~w_pol_nxt;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_out   <= w_pol_nxt;
                    end
                endcase
            end
        end
    end

    // Read mux registered every cycle for a fixed one-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            case (address)
                ADDR_STATUS: r_readdata <= {30'd0, r_out, w_busy};
                ADDR_HIGH:   r_readdata <= 32'(r_high_cnt);
                ADDR_LOW:    r_readdata <= 32'(r_low_cnt);
                ADDR_NUM:    r_readdata <= 32'(r_pulse_num);
                ADDR_MASK:   r_readdata <= {31'd0, r_irq_mask};
                ADDR_DONE:   r_readdata <= {31'd0, r_done};
                ADDR_REMAIN: r_readdata <= 32'(r_remain);
                default:     r_readdata <= '0;
            endcase
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_out;
    assign irq      = r_done & r_irq_mask;

endmodule

// File: tb/tb_t_pulse_gen.sv
// Directed testbench for t_pulse_gen: hand-computed waveforms and register reads.
module tb_t_pulse_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        out_port;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_a [10] = '{32'd1, 32'd1, 32'd1, 32'd0, 32'd0,
                                32'd1, 32'd1, 32'd1, 32'd0, 32'd0};
    logic [31:0] exp_c [4]  = '{32'd0, 32'd1, 32'd0, 32'd0};

    t_pulse_gen #(
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Write held across one rising edge; returns at the following falling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    // Address presented for one edge; readdata captured at the following falling edge.
    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(negedge clk);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    initial begin
        logic [31:0] rdv;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        reset_n    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out", 32'(out_port), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rdata", readdata, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        rd(3'd2, rdv); chk("rst_high", rdv, 32'd0);
        rd(3'd1, rdv); chk("rst_status", rdv, 32'd0);

        // Two pulses, HIGH=3 LOW=2, POL=0, irq enabled
        wr(3'd2, 32'd3); wr(3'd3, 32'd2); wr(3'd4, 32'd2); wr(3'd5, 32'd1);
        rd(3'd2, rdv); chk("high_readback", rdv, 32'd3);
        wr(3'd0, 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("trainA_%0d", i), 32'(out_port), exp_a[i]);
            @(negedge clk);
        end
        chk("trainA_idle", 32'(out_port), 32'd0);
        chk("trainA_irq", 32'(irq), 32'd1);
        rd(3'd6, rdv); chk("trainA_done", rdv, 32'd1);
        rd(3'd1, rdv); chk("trainA_status", rdv, 32'd0);
        rd(3'd7, rdv); chk("trainA_remain", rdv, 32'd0);

        // DONE_CAP clear, then clear coinciding with set
        wr(3'd6, 32'd0);
        chk("clr_irq", 32'(irq), 32'd0);
        rd(3'd6, rdv); chk("clr_done", rdv, 32'd0);
        wr(3'd2, 32'd1); wr(3'd3, 32'd1); wr(3'd4, 32'd1);
        wr(3'd0, 32'd1);
        chk("short_high", 32'(out_port), 32'd1);
        @(negedge clk);
        chk("short_low", 32'(out_port), 32'd0);
        wr(3'd6, 32'd0);
        chk("clr_vs_set_irq", 32'(irq), 32'd0);
        rd(3'd6, rdv); chk("clr_vs_set_done", rdv, 32'd0);
        rd(3'd1, rdv); chk("clr_vs_set_status", rdv, 32'd0);

        // Continuous mode, then STOP during HIGH
        wr(3'd4, 32'd0);
        wr(3'd0, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("cont_%0d", i), 32'(out_port), (i % 2 == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk("cont_pre_stop", 32'(out_port), 32'd1);
        wr(3'd0, 32'd2);
        chk("stop_out", 32'(out_port), 32'd0);
        rd(3'd1, rdv); chk("stop_status", rdv, 32'd0);
        rd(3'd6, rdv); chk("stop_done", rdv, 32'd0);
        rd(3'd7, rdv); chk("cont_remain", rdv, 32'd0);
        chk("stop_out_hold", 32'(out_port), 32'd0);

        // Zero phase lengths, START while busy, START+STOP
        wr(3'd2, 32'd0); wr(3'd3, 32'd0); wr(3'd4, 32'd3);
        wr(3'd0, 32'd1);
        chk("zero_0", 32'(out_port), 32'd1);
        wr(3'd0, 32'd1);
        chk("start_busy", 32'(out_port), 32'd0);
        rd(3'd7, rdv); chk("busy_remain", rdv, 32'd3);
        chk("zero_2", 32'(out_port), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("zero_%0d", i + 3), 32'(out_port), exp_c[i]);
        end
        chk("zero_irq", 32'(irq), 32'd1);
        rd(3'd7, rdv); chk("zero_remain_end", rdv, 32'd0);
        wr(3'd6, 32'd0);
        wr(3'd0, 32'd3);
        chk("startstop_out", 32'(out_port), 32'd0);
        rd(3'd1, rdv); chk("startstop_status", rdv, 32'd0);

        // POL=1 single pulse with in-flight status reads
        wr(3'd2, 32'd2); wr(3'd3, 32'd1); wr(3'd4, 32'd1);
        wr(3'd0, 32'd4);
        chk("pol_idle", 32'(out_port), 32'd1);
        wr(3'd0, 32'd5);
        chk("pol_0", 32'(out_port), 32'd0);
        rd(3'd1, rdv); chk("pol_status_high", rdv, 32'd1);
        chk("pol_1", 32'(out_port), 32'd0);
        rd(3'd7, rdv); chk("pol_remain", rdv, 32'd1);
        chk("pol_2", 32'(out_port), 32'd1);
        rd(3'd1, rdv); chk("pol_status_low", rdv, 32'd3);
        chk("pol_idle_after", 32'(out_port), 32'd1);
        rd(3'd1, rdv); chk("pol_status_idle", rdv, 32'd2);
        chk("pol_irq", 32'(irq), 32'd1);
        wr(3'd0, 32'd0);
        chk("pol_back0", 32'(out_port), 32'd0);

        // Asynchronous reset mid-HIGH with DONE_CAP still set
        wr(3'd2, 32'd5); wr(3'd3, 32'd1); wr(3'd4, 32'd1);
        wr(3'd0, 32'd1);
        @(negedge clk);
        chk("pre_rst_out", 32'(out_port), 32'd1);
        chk("pre_rst_irq", 32'(irq), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_out", 32'(out_port), 32'd0);
        chk("async_rst_irq", 32'(irq), 32'd0);
        chk("async_rst_rdata", readdata, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(3'd1, rdv); chk("post_rst_status", rdv, 32'd0);
        rd(3'd6, rdv); chk("post_rst_done", rdv, 32'd0);
        rd(3'd2, rdv); chk("post_rst_high", rdv, 32'd0);
        repeat (3) @(negedge clk);
        chk("post_rst_out", 32'(out_port), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
